// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int NUM_CH             = 4;
    localparam int GAP_CYCLES_DEF     = 50000;
    localparam int TIMEOUT_CYCLES_DEF = 250000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } arb_state_t;

    // Counter width for a count of n cycles; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pending_slot.sv
// One request channel: pending flag, held byte and lost-event detection.
module arb_pending_slot (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse,
    input  logic [7:0] data,
    input  logic       clear,
    output logic       pending,
    output logic [7:0] hold,
    output logic       drop
);

    logic       pending_reg;
    logic [7:0] hold_reg;
    logic       accept;

    // A new event is taken when the slot is free or is being freed this cycle.
    assign accept  = pulse & (~pending_reg | clear);
    assign drop    = pulse & pending_reg & ~clear;
    assign pending = pending_reg;
    assign hold    = hold_reg;

    // Pending flag and hold register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg <= 1'b0;
            hold_reg    <= 8'h00;
        end else begin
            if (pulse) begin
                pending_reg <= 1'b1;
            end else if (clear) begin
                pending_reg <= 1'b0;
            end
            if (accept) begin
                hold_reg <= data;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Fixed-priority arbiter feeding single bytes from four event channels
// into one byte transmitter, with an inter-frame gap and a done timeout.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_pulse,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [7:0] req_data2,
    input  logic [7:0] req_data3,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout,
    output logic [7:0] drop_cnt
);

    localparam int WAIT_W = cnt_width(TIMEOUT_CYCLES);
    localparam int GAP_W  = cnt_width(GAP_CYCLES);

    arb_state_t         state_reg, state_next;
    logic [NUM_CH-1:0]  pending;
    logic [NUM_CH-1:0]  drop;
    logic [NUM_CH-1:0]  clear_vec;
    logic [7:0]         req_data_arr [NUM_CH];
    logic [7:0]         hold_arr     [NUM_CH];
    logic [1:0]         grant_reg;
    logic [7:0]         tx_data_reg;
    logic               timeout_reg, timeout_next;
    logic               load_sel;
    logic [1:0]         sel_idx;
    logic [WAIT_W-1:0]  wait_cnt_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic [7:0]         drop_cnt_reg;
    logic [2:0]         drop_sum;
    logic [8:0]         drop_total;

    assign req_data_arr[0] = req_data0;
    assign req_data_arr[1] = req_data1;
    assign req_data_arr[2] = req_data2;
    assign req_data_arr[3] = req_data3;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            assign clear_vec[gi] = (state_reg == ST_START) && (grant_reg == 2'(gi));
            arb_pending_slot u_slot (
                .clk     (clk),
                .rst     (rst),
                .pulse   (req_pulse[gi]),
                .data    (req_data_arr[gi]),
                .clear   (clear_vec[gi]),
                .pending (pending[gi]),
                .hold    (hold_arr[gi]),
                .drop    (drop[gi])
            );
        end
    endgenerate

    // Lowest pending index wins: scan downwards so the last hit is the lowest.
    always_comb begin
        sel_idx = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_idx = 2'(i);
            end
        end
    end

    // Next-state logic and transition-time controls.
    always_comb begin
        state_next   = state_reg;
        load_sel     = 1'b0;
        timeout_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (|pending) begin
                    load_sel   = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    state_next = ST_GAP;
                end else if (wait_cnt_reg == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_next = 1'b1;
                    state_next   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Number of events lost across all channels this cycle.
    always_comb begin
        drop_sum = 3'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            drop_sum = drop_sum + {2'b00, drop[i]};
        end
        drop_total = {1'b0, drop_cnt_reg} + {6'd0, drop_sum};
    end

    // State register, selected byte/grant, counters and saturating drop count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            grant_reg    <= 2'd0;
            tx_data_reg  <= 8'h00;
            timeout_reg  <= 1'b0;
            wait_cnt_reg <= '0;
            gap_cnt_reg  <= '0;
            drop_cnt_reg <= 8'h00;
        end else begin
            state_reg   <= state_next;
            timeout_reg <= timeout_next;
            if (load_sel) begin
                grant_reg   <= sel_idx;
                tx_data_reg <= hold_arr[sel_idx];
            end
            // Counters restart on any state change so each entry begins at zero.
            if (state_next != state_reg) begin
                wait_cnt_reg <= '0;
                gap_cnt_reg  <= '0;
            end else begin
                if (state_reg == ST_WAIT_DONE) wait_cnt_reg <= wait_cnt_reg + 1'b1;
                if (state_reg == ST_GAP)       gap_cnt_reg  <= gap_cnt_reg + 1'b1;
            end
            drop_cnt_reg <= drop_total[8] ? 8'hFF : drop_total[7:0];
        end
    end

    assign tx_start = (state_reg == ST_START);
    assign busy     = (state_reg != ST_IDLE);
    assign tx_data  = tx_data_reg;
    assign grant    = grant_reg;
    assign timeout  = timeout_reg;
    assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with short gap and timeout values.
module tb_uart_tx_arbiter;

    localparam int GAP = 4;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_pulse;
    logic [7:0] req_data0, req_data1, req_data2, req_data3;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] grant;
    logic       busy;
    logic       timeout;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_pulse (req_pulse),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .req_data2 (req_data2),
        .req_data3 (req_data3),
        .tx_done   (tx_done),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, tx_start, 0);
        chk({tag, "_data"},  tx_data,  0);
        chk({tag, "_grant"}, grant,    0);
        chk({tag, "_busy"},  busy,     0);
        chk({tag, "_tmo"},   timeout,  0);
        chk({tag, "_drop"},  drop_cnt, 0);
    endtask

    initial begin
        rst = 1'b1; req_pulse = 4'b0; tx_done = 1'b0;
        req_data0 = 8'h00; req_data1 = 8'h00; req_data2 = 8'h00; req_data3 = 8'h00;
        repeat (2) cyc();
        chk_reset_outputs("rst");
        rst = 1'b0;

        // Single request on channel 2: start two cycles later, then the gap.
        cyc();
        req_pulse = 4'b0100; req_data2 = 8'h33;
        cyc(); req_pulse = 4'b0;
        chk("t1_n1_start", tx_start, 0);
        cyc();
        chk("t1_start", tx_start, 1);
        chk("t1_data",  tx_data,  8'h33);
        chk("t1_grant", grant,    2);
        chk("t1_busy",  busy,     1);
        cyc();
        chk("t1_start_1cy", tx_start, 0);
        tx_done = 1'b1;
        cyc(); tx_done = 1'b0;
        for (int i = 0; i < GAP; i++) begin
            chk("t1_gap_busy", busy, 1);
            tx_done = (i == 1);        // stray done inside the gap is ignored
            cyc();
        end
        tx_done = 1'b0;
        chk("t1_idle_busy", busy, 0);
        chk("t1_data_hold", tx_data, 8'h33);

        // Channels 0 and 3 together: 0 first, 3 after done plus the gap.
        req_pulse = 4'b1001; req_data0 = 8'hA0; req_data3 = 8'hD3;
        cyc(); req_pulse = 4'b0;
        cyc();
        chk("t2_start0", tx_start, 1);
        chk("t2_data0",  tx_data,  8'hA0);
        chk("t2_grant0", grant,    0);
        cyc(); tx_done = 1'b1;
        cyc(); tx_done = 1'b0;
        for (int i = 0; i < GAP; i++) begin
            chk("t2_gap_nostart", tx_start, 0);
            cyc();
        end
        chk("t2_idle_busy", busy, 0);
        cyc();
        chk("t2_start3", tx_start, 1);
        chk("t2_data3",  tx_data,  8'hD3);
        chk("t2_grant3", grant,    3);
        cyc(); tx_done = 1'b1;
        cyc(); tx_done = 1'b0;
        repeat (GAP) cyc();
        chk("t2_end_busy", busy, 0);

        // Three pulses on channel 1: first sent, second latched, third dropped.
        req_pulse = 4'b0010; req_data1 = 8'h21;
        cyc(); req_pulse = 4'b0;
        cyc();
        chk("t3_data1", tx_data, 8'h21);
        cyc();
        req_pulse = 4'b0010; req_data1 = 8'h22;
        cyc();
        req_pulse = 4'b0010; req_data1 = 8'h23;
        cyc(); req_pulse = 4'b0;
        chk("t3_drop1", drop_cnt, 1);
        chk("t3_tx_data_stable", tx_data, 8'h21);
        tx_done = 1'b1;
        cyc(); tx_done = 1'b0;
        repeat (GAP) cyc();
        chk("t3_idle", busy, 0);
        cyc();
        chk("t3_start2", tx_start, 1);
        chk("t3_data2",  tx_data,  8'h22);

        // No done for the 0x22 frame: timeout TMO cycles after entering WAIT_DONE.
        cyc();
        for (int k = 1; k <= TMO; k++) begin
            chk("t4_no_tmo", timeout, 0);
            cyc();
        end
        chk("t4_tmo",      timeout, 1);
        chk("t4_tmo_busy", busy,    1);
        cyc();
        chk("t4_tmo_1cy", timeout, 0);
        repeat (3) cyc();
        chk("t4_idle", busy, 0);
        cyc();
        chk("t4_no_resend", tx_start, 0);
        chk("t4_no_resend_busy", busy, 0);

        // Reset during WAIT_DONE with channel 1 pending.
        req_pulse = 4'b0001; req_data0 = 8'h55;
        cyc(); req_pulse = 4'b0;
        cyc();
        chk("t5_data", tx_data, 8'h55);
        cyc();
        req_pulse = 4'b0010; req_data1 = 8'h66;
        cyc(); req_pulse = 4'b0;
        rst = 1'b1;
        cyc(); rst = 1'b0;
        chk_reset_outputs("t5_rst");
        tx_done = 1'b1;
        cyc(); tx_done = 1'b0;
        chk("t5_late_done", busy, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_lost_pend", tx_start, 0);
        end

        // Continuous pulses on every channel: exact early counts, then saturation.
        req_pulse = 4'b1111;
        req_data0 = 8'h01; req_data1 = 8'h02; req_data2 = 8'h03; req_data3 = 8'h04;
        cyc();
        chk("t6_drop0", drop_cnt, 0);
        cyc();
        chk("t6_drop4", drop_cnt, 4);
        cyc();
        chk("t6_drop7", drop_cnt, 7);
        repeat (80) cyc();
        chk("t6_sat", drop_cnt, 8'hFF);
        repeat (2) cyc();
        chk("t6_sat_hold", drop_cnt, 8'hFF);
        req_pulse = 4'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 50000, idle cycles enforced after each frame before the next grant (1 ms at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 250000, maximum cycles to wait for tx_done before abandoning a frame.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_pulse  input  4  one-cycle event pulses from debounced keys/sensors; bit 0 = highest priority (CO alarm).
REQ-006 req_data0..req_data3  input  8 each  byte to send for the matching channel, sampled in the pulse cycle.
REQ-007 tx_done  input  1  one-cycle completion pulse from the byte transmitter (over_rx).
REQ-008 tx_start  output  1  one-cycle start pulse to the byte transmitter (send_en).
REQ-009 tx_data  output  8  byte presented to the transmitter, stable from tx_start until leaving WAIT_DONE.
REQ-010 grant  output  2  index of the channel currently or last served.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 timeout  output  1  one-cycle pulse when a frame is abandoned.
REQ-013 drop_cnt  output  8  saturating count of lost events.

Function
REQ-014 Each channel shall own a pending flag and an 8-bit hold register; req_pulse[i] sets pending[i] and loads req_dataI into hold[i].
REQ-015 A req_pulse[i] while pending[i] is set and not being cleared that cycle shall be discarded (hold[i] unchanged), and drop_cnt shall increment, saturating at 255.
REQ-016 If req_pulse[i] coincides with clearing of pending[i], pending[i] shall remain set with the new byte and no drop is counted.
REQ-017 FSM states: IDLE, START, WAIT_DONE, GAP.
REQ-018 IDLE: if any pending bit is set, select the lowest set index, load tx_data from its hold register, update grant, go START; else stay.
REQ-019 START: assert tx_start for exactly one cycle, clear pending[grant], go WAIT_DONE.
REQ-020 WAIT_DONE: on tx_done go GAP; if the wait counter reaches TIMEOUT_CYCLES-1 without tx_done, pulse timeout and go GAP.
REQ-021 GAP: count GAP_CYCLES cycles, then go IDLE; new requests still latch during GAP.
REQ-022 tx_done in any state other than WAIT_DONE shall be ignored.
REQ-023 Latency: req_pulse in cycle N with FSM in IDLE shall give tx_start high in cycle N+2.
REQ-024 Priority is fixed and re-evaluated only in IDLE; a lower channel waits while any higher channel is pending.
REQ-025 Wait and gap counters shall be sized by $clog2 of their parameter and cleared on every state entry.

Reset
REQ-026 With rst high at a clock edge, state shall be IDLE and all pending flags, hold registers and counters zero.
REQ-027 Outputs in reset: tx_start 0, tx_data 0x00, grant 0, busy 0, timeout 0, drop_cnt 0.
REQ-028 Reset mid-frame shall abandon the frame with no tx_start or timeout pulse in the following cycle; a late tx_done shall be ignored.

Structure
REQ-029 Package uart_arb_pkg shall hold the state enumeration, NUM_CH=4, and the default GAP_CYCLES and TIMEOUT_CYCLES constants.
REQ-030 One sub-module, arb_pending_slot (pending flag, hold register, drop detect), shall be instantiated once per channel.

Verification
REQ-031 req_pulse=4'b0100 with req_data2=0x33, FSM idle -> tx_start in cycle N+2, tx_data=0x33, grant=2; tx_done -> busy stays high GAP_CYCLES, then low.
REQ-032 Simultaneous req_pulse=4'b1001 (data0=0xA0, data3=0xD3) -> 0xA0 sent first, 0xD3 only after tx_done plus GAP_CYCLES.
REQ-033 Three req_pulse[1] while the first byte is in WAIT_DONE -> second pulse latched, third dropped, drop_cnt=1; 256+ drops -> drop_cnt holds 255.
REQ-034 No tx_done after tx_start -> timeout pulses at TIMEOUT_CYCLES cycles after entering WAIT_DONE, FSM enters GAP, pending[grant] already cleared.
REQ-035 rst asserted for one cycle during WAIT_DONE with channel 1 pending -> all outputs reset values next cycle, pending lost, a subsequent tx_done causes no action.
